alarm_timekeeper: RTL

Parametrised time-of-day and multi-alarm core for the Basys2 alarm-clock design. It replaces the fixed single-alarm timekeeping with N alarms, 12/24-hour display mode, snooze and a fast simulation/demo tick. Outputs are BCD digits for the downstream seven-segment scanner and per-alarm ring flags for the LED driver. Board-top logic maps the switches and buttons onto its inputs.

---
 rtl/alarm_pkg.sv | 46 ++++
 rtl/bcd_counter.sv | 36 +++
 rtl/alarm_timekeeper.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared constants, types and BCD helpers for the alarm_timekeeper block.
// Times are held as two-digit BCD bytes in 24-hour form throughout.
package alarm_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
    } alarm_t;

    typedef struct packed {
        logic       pm;
        logic [7:0] hh;
    } hour12_t;

    // Next value of a two-digit BCD field that wraps to 00 after limit.
    function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] limit);
        if (value == limit) begin
            return 8'h00;
        end
        if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

    // 24-hour BCD hour to 12-hour BCD hour plus PM flag (00 shows as 12 AM).
    function automatic hour12_t to_12h(input logic [7:0] hh24);
        logic [4:0] bin;
        hour12_t    r;
        bin  = 5'(hh24[7:4]) * 5'd10 + 5'(hh24[3:0]);
        r.pm = (bin >= 5'd12);
        if (r.pm) begin
            bin = bin - 5'd12;
        end
        if (bin == 5'd0) begin
            bin = 5'd12;
        end
        r.hh = (bin >= 5'd10) ? {4'd1, 4'(bin - 5'd10)} : {4'd0, bin[3:0]};
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD counter wrapping after MAX; clear has priority over inc.
// carry_o flags the increment that wraps the counter back to 00.
module bcd_counter
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [7:0] value_o,
    output logic       carry_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = 8'h00;
        end else if (inc_i) begin
            value_d = bcd_next(value_q, MAX);
        end
    end

    // NOTE: state is updated with <= so every counter samples pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        value_q <= value_d;
    end

    assign value_o = value_q;
    assign carry_o = inc_i && !clear_i && (value_q == MAX);

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day core with NUM_ALARMS alarms, snooze, 12/24-hour display and fast tick.
// Define HOURLY_CHIME_EN to build the one-cycle chime pulse on every hh:00:00.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int CLK_DIV    = 50_000_000,
    parameter int FAST_DIV   = 4,
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_MIN = 9,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  fast,
    input  logic                  mode_12h,
    input  logic                  set_time,
    input  logic                  set_alarm,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic                  inc_min,
    input  logic                  inc_hour,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  ack,
    output logic [7:0]            hh_bcd,
    output logic [7:0]            mm_bcd,
    output logic [7:0]            ss_bcd,
    output logic                  pm,
    output logic [NUM_ALARMS-1:0] ring,
    output logic                  sec_tick,
    output logic                  chime
);

    localparam int DIV_MAX = (CLK_DIV > FAST_DIV) ? CLK_DIV : FAST_DIV;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [DIV_W-1:0] CLK_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [5:0]       SNZ_LOAD  = 6'(SNOOZE_MIN);

    // ---------------- prescaler ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             fast_q;
    logic             tick_q;
    logic             wrap;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        wrap  = 1'b0;
        // A change of rate or a time edit restarts the second from zero.
        if (set_time || (fast != fast_q)) begin
            div_d = '0;
        end else if (div_q == (fast ? FAST_LAST : CLK_LAST)) begin
            div_d = '0;
            wrap  = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        fast_q <= fast;
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= wrap;
        end
    end

    assign sec_tick = tick_q;

    // ---------------- time of day ----------------
    logic [7:0] ss_cur, mm_cur, hh_cur;
    logic       ss_carry, mm_carry, hh_carry_unused;
    logic       hour_roll;

    assign hour_roll = mm_carry && !set_time;

    bcd_counter #(.MAX(SEC_MAX)) u_ss (
        .clk_i   (MCLK),
        .clear_i (reset || set_time),
        .inc_i   (wrap),
        .value_o (ss_cur),
        .carry_o (ss_carry)
    );

    bcd_counter #(.MAX(MIN_MAX)) u_mm (
        .clk_i   (MCLK),
        .clear_i (reset),
        .inc_i   (ss_carry || (set_time && inc_min)),
        .value_o (mm_cur),
        .carry_o (mm_carry)
    );

    bcd_counter #(.MAX(HOUR_MAX)) u_hh (
        .clk_i   (MCLK),
        .clear_i (reset),
        .inc_i   (hour_roll || (set_time && inc_hour)),
        .value_o (hh_cur),
        .carry_o (hh_carry_unused)
    );

    // ---------------- alarm registers ----------------
    alarm_t alarms [NUM_ALARMS];

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
        logic       edit_sel;
        logic [7:0] hh_v, mm_v;
        logic       hh_carry_unused_a, mm_carry_unused_a;

        assign edit_sel = set_alarm && !set_time && (alarm_sel == SEL_W'(i));

        bcd_counter #(.MAX(MIN_MAX)) u_alarm_mm (
            .clk_i   (MCLK),
            .clear_i (reset),
            .inc_i   (edit_sel && inc_min),
            .value_o (mm_v),
            .carry_o (mm_carry_unused_a)
        );

        bcd_counter #(.MAX(HOUR_MAX)) u_alarm_hh (
            .clk_i   (MCLK),
            .clear_i (reset),
            .inc_i   (edit_sel && inc_hour),
            .value_o (hh_v),
            .carry_o (hh_carry_unused_a)
        );

        assign alarms[i] = '{hh: hh_v, mm: mm_v};
    end

    // ---------------- match, ring and snooze ----------------
    alarm_t                next_hhmm;
    logic [NUM_ALARMS-1:0] match, expire;
    logic [NUM_ALARMS-1:0] ring_q, ring_d;
    logic [5:0]            snz_q [NUM_ALARMS];
    logic [5:0]            snz_d [NUM_ALARMS];

    // hh:mm the time moves to on a seconds wrap; only consulted when ss_carry is set.
    always_comb begin
        next_hhmm.mm = bcd_next(mm_cur, MIN_MAX);
        next_hhmm.hh = (mm_cur == MIN_MAX) ? bcd_next(hh_cur, HOUR_MAX) : hh_cur;
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i]  = ss_carry && alarm_en[i] && (next_hhmm == alarms[i]);
            expire[i] = ss_carry && alarm_en[i] && (snz_q[i] == 6'd1);
        end
    end

    always_comb begin
        ring_d = ring_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            snz_d[i] = snz_q[i];
            if (ss_carry && (snz_q[i] != 6'd0)) begin
                snz_d[i] = snz_q[i] - 6'd1;
            end
            if (ack) begin
                ring_d[i] = 1'b0;
                snz_d[i]  = 6'd0;
            end else if (snooze && ring_q[i]) begin
                ring_d[i] = 1'b0;
                snz_d[i]  = SNZ_LOAD;
            end
            if (!alarm_en[i]) begin
                ring_d[i] = 1'b0;
                snz_d[i]  = 6'd0;
            end
            // A fresh match or snooze expiry overrides any silence request on the same edge.
            if (match[i] || expire[i]) begin
                ring_d[i] = 1'b1;
            end
        end
    end

    // NOTE: the per-alarm snooze counters are ordinary flops, so reset clears them explicitly.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            ring_q <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                snz_q[i] <= 6'd0;
            end
        end else begin
            ring_q <= ring_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                snz_q[i] <= snz_d[i];
            end
        end
    end

    assign ring = ring_q;

    // ---------------- display ----------------
    alarm_t  shown;
    hour12_t h12;

    always_comb begin
        shown  = '{hh: hh_cur, mm: mm_cur};
        ss_bcd = ss_cur;
        if (set_alarm && !set_time) begin
            shown  = '0;
            ss_bcd = 8'h00;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_sel == SEL_W'(i)) begin
                    shown = alarms[i];
                end
            end
        end
        h12    = to_12h(shown.hh);
        mm_bcd = shown.mm;
        hh_bcd = mode_12h ? h12.hh : shown.hh;
        pm     = mode_12h && h12.pm;
    end

    // ---------------- hourly chime ----------------
`ifdef HOURLY_CHIME_EN
    logic chime_q;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= hour_roll;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

endmodule
